// File: rtl/lut_serial_programmer.sv
// ---------------------------------------------------------------------------
// lut_serial_programmer
//
// Host-side transmitter for a serially loaded lookup table. One accepted
// command either shifts a complete table image into the LUT (MSB first,
// under scs_n) or pulses the LUT's rotate clock N times (under srot_n).
// Each serial clock phase lasts HALF clk cycles.
//
// Handshake: a command is accepted on a clk edge where start_valid and
// start_ready are both high. start_ready is high only in IDLE. Inputs
// table_in, cmd_rot and rot_count are sampled only at that edge. done
// pulses for one cycle when the command has fully completed.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start_valid     command request
//   start_ready     high while idle
//   cmd_rot         0 = load table, 1 = rotate
//   table_in        table image, entry i at [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH]
//   rot_count       number of entries to rotate
//   busy            command in progress
//   done            one-cycle completion pulse
//   sd, sclk        serial data / shift clock (LUT samples on sclk rise)
//   scs_n, srot_n   load select / rotate select, active-low
// ---------------------------------------------------------------------------
module lut_serial_programmer #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 3,
    parameter int HALF      = 2,
    localparam int TABLE_BITS = (2 ** IN_WIDTH) * OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  cmd_rot,
    input  logic [TABLE_BITS-1:0] table_in,
    input  logic [IN_WIDTH-1:0]   rot_count,
    output logic                  busy,
    output logic                  done,
    output logic                  sd,
    output logic                  sclk,
    output logic                  scs_n,
    output logic                  srot_n
);

    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW = $clog2(TABLE_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    // Holds the bits still to be sent after the one currently on sd.
    logic [TABLE_BITS-1:0] shreg_q, shreg_d;
    logic                  sd_q, sd_d;
    logic                  sclk_q, sclk_d;
    logic                  scs_n_q, scs_n_d;
    logic                  srot_n_q, srot_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    // Set by a zero-length rotate so done pulses one edge after accept.
    logic                  zrot_q, zrot_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        shreg_d     = shreg_q;
        sd_d        = sd_q;
        sclk_d      = sclk_q;
        scs_n_d     = scs_n_q;
        srot_n_d    = srot_n_q;
        busy_d      = busy_q;
        done_d      = zrot_q;
        zrot_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (!cmd_rot) begin
                        shreg_d     = {table_in[TABLE_BITS-2:0], 1'b0};
                        sd_d        = table_in[TABLE_BITS-1];
                        remaining_d = RW'(TABLE_BITS);
                        scs_n_d     = 1'b0;
                        busy_d      = 1'b1;
                        phase_d     = PW'(HALF - 1);
                        state_d     = S_LOW;
                    end else if (rot_count != '0) begin
                        // Zero data keeps sd low for the whole rotate.
                        shreg_d     = '0;
                        sd_d        = 1'b0;
                        remaining_d = RW'(rot_count);
                        srot_n_d    = 1'b0;
                        busy_d      = 1'b1;
                        phase_d     = PW'(HALF - 1);
                        state_d     = S_LOW;
                    end else begin
                        zrot_d = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (phase_q == '0) begin
                    sclk_d  = 1'b1;
                    phase_d = PW'(HALF - 1);
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_q == '0) begin
                    sclk_d  = 1'b0;
                    phase_d = PW'(HALF - 1);
                    if (remaining_q > RW'(1)) begin
                        // sd only moves together with the sclk fall.
                        remaining_d = remaining_q - 1'b1;
                        sd_d        = shreg_q[TABLE_BITS-1];
                        shreg_d     = {shreg_q[TABLE_BITS-2:0], 1'b0};
                        state_d     = S_LOW;
                    end else begin
                        state_d = S_TAIL;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_TAIL: begin
                if (phase_q == '0) begin
                    scs_n_d  = 1'b1;
                    srot_n_d = 1'b1;
                    sd_d     = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            shreg_q     <= '0;
            sd_q        <= 1'b0;
            sclk_q      <= 1'b0;
            scs_n_q     <= 1'b1;
            srot_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zrot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            shreg_q     <= shreg_d;
            sd_q        <= sd_d;
            sclk_q      <= sclk_d;
            scs_n_q     <= scs_n_d;
            srot_n_q    <= srot_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zrot_q      <= zrot_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign sd          = sd_q;
    assign sclk        = sclk_q;
    assign scs_n       = scs_n_q;
    assign srot_n      = srot_n_q;

endmodule

// File: doc/lut_serial_programmer.md
# lut_serial_programmer

Host-side transmitter for the serially loaded lookup table. It takes a complete table as one parallel word, or a rotate-by-N-entries command, through a valid/ready handshake. It then drives the table's serial configuration pins (data, shift clock, chip-select, rotate strobe) at a divided rate. It sits between on-chip control logic and the LUT pins, so a whole table reload or a rotation becomes one transaction.

## Interface
Parameters:
- IN_WIDTH, 4, LUT select width; table holds 2**IN_WIDTH entries
- OUT_WIDTH, 3, bits per entry; one rotate step moves one entry
- HALF, 2, serial clock half-period in clk cycles (≥1)
- TABLE_BITS, 2**IN_WIDTH*OUT_WIDTH (48), derived; not overridden

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous, active-low (reset rst_n, asynchronous, active-low; clock clk)
- start_valid  in  1  command request
- start_ready  out  1  high when idle; command accepted on a clk edge with start_valid & start_ready
- cmd_rot  in  1  0 = load table, 1 = rotate
- table_in  in  TABLE_BITS  table image; entry i at bits [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH]
- rot_count  in  IN_WIDTH  number of entries to rotate
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- sd  out  1  serial data to the LUT
- sclk  out  1  serial shift clock; the LUT acts on its rising edge
- scs_n  out  1  load select, active-low
- srot_n  out  1  rotate select, active-low

## Operation
- All outputs are registered. Reset values: sclk=0, sd=0, scs_n=1, srot_n=1, busy=0, done=0. start_ready=1, since it decodes the IDLE state.
- FSM states: IDLE, LOW, HIGH, TAIL. A down-counter times each phase for HALF cycles. A bit/step counter tracks the remaining bits or steps.
- IDLE, on accept with cmd_rot=0:
  - latch table_in into the internal shift register
  - remaining = TABLE_BITS
  - scs_n←0, sd←table_in[TABLE_BITS-1], busy←1
  - go to LOW
- IDLE, on accept with cmd_rot=1 and rot_count≠0:
  - remaining = rot_count
  - srot_n←0, sd←0, busy←1
  - go to LOW
- IDLE, on accept with cmd_rot=1 and rot_count=0: no pin activity. done pulses on the next edge, and the FSM stays in IDLE.
- LOW: sclk=0 for HALF cycles, then sclk←1 and go to HIGH.
- HIGH: sclk=1 for HALF cycles. At the end:
  - if remaining>1: decrement, shift the data register left by one, sd←next MSB, sclk←0, go to LOW
  - else: sclk←0, go to TAIL
- TAIL: sclk=0 for HALF cycles. At the end: scs_n←1, srot_n←1, sd←0, busy←0, done←1 (for that one cycle), go to IDLE.
- Bit order is MSB first (table bit TABLE_BITS-1 first, bit 0 last). After a full load the LUT's parallel table equals table_in exactly.
- Rotate by k moves the LUT image by k*OUT_WIDTH bits, i.e. right-rotates the table by k entries. scs_n stays 1 throughout a rotate, so the load path never competes.
- table_in, cmd_rot and rot_count are sampled only at accept. Later changes have no effect.
- start_valid while busy is ignored; nothing is queued.
- Reset mid-command returns all outputs to reset values immediately. The LUT is left partially shifted, and the host must reissue the load.

## Timing
- sd changes only on the same clk edge that drives sclk low, or on the accept edge. This gives ≥HALF cycles of setup and ≥HALF cycles of hold around each sclk rise.
- scs_n/srot_n assert at the accept edge. They deassert HALF cycles after the last sclk fall.
- Load latency, accept edge to done edge: TABLE_BITS*2*HALF + HALF = 194 cycles (defaults). The LUT sees exactly TABLE_BITS rising sclk edges.
- Rotate by k: k*2*HALF + HALF cycles, with exactly k rising sclk edges.
- A new accept is possible on the edge after done, because start_ready=1 in that cycle.

## Test plan
- Reset: assert rst_n=0 mid-stream -> immediately sclk=0, scs_n=1, srot_n=1, sd=0, busy=0, start_ready=1.
- Load table_in=48'hFEDCBA987654 with a behavioural LUT model on the pins -> 48 sclk rises; model table = 48'hFEDCBA987654; done at 194 cycles; LUT sel=0 yields 3'b100.
- Load 48'h000000000001, then rotate with rot_count=1 -> 1 sclk rise with srot_n=0, scs_n=1; model table = 48'h200000000000; done 6 cycles after accept.
- Rotate with rot_count=0 -> no sclk edge, scs_n/srot_n stay 1, done the cycle after accept.
- Hold start_valid high and change table_in during a load -> only one accept occurs (start_ready=0 while busy); the transmitted data equals the value at accept; the second command is accepted on the edge after done.
- HALF=1 build, load all-ones -> sclk period of 2 cycles, done at 97 cycles, model table all ones; sd stable across every sclk rise.
